// File: rtl/eth_pkg.sv
// Shared constants, state encoding and header packing for the Ethernet header inserters.
package eth_pkg;

  localparam int ETH_HDR_LEN = 14;
  localparam int DEST_OFS    = 0;
  localparam int SRC_OFS     = 6;
  localparam int TYPE_OFS    = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } eth_tx_state_t;

  // Packs the header so that byte offset 0 sits in the top byte of the vector.
  function automatic logic [8*ETH_HDR_LEN-1:0] pack_hdr(
    input logic [47:0] dest_mac,
    input logic [47:0] src_mac,
    input logic [15:0] eth_type
  );
    logic [8*ETH_HDR_LEN-1:0] hdr;
    hdr = '0;
    hdr[8*(ETH_HDR_LEN-DEST_OFS)-1 -: 48] = dest_mac;
    hdr[8*(ETH_HDR_LEN-SRC_OFS)-1 -: 48]  = src_mac;
    hdr[8*(ETH_HDR_LEN-TYPE_OFS)-1 -: 16] = eth_type;
    return hdr;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered AXI4-Stream output buffer: output register plus temp register,
// so that both the master outputs and the upstream ready are driven from flops.
module axis_skid_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  logic [DATA_WIDTH-1:0] out_tdata_reg, temp_tdata_reg;
  logic                  out_tlast_reg, temp_tlast_reg;
  logic                  out_tuser_reg, temp_tuser_reg;
  logic                  out_tvalid_reg, out_tvalid_next;
  logic                  temp_tvalid_reg, temp_tvalid_next;
  logic                  tready_reg, tready_early;
  logic                  store_in_to_out, store_in_to_temp, store_temp_to_out;

  assign s_axis_tready = tready_reg;
  assign m_axis_tdata  = out_tdata_reg;
  assign m_axis_tvalid = out_tvalid_reg;
  assign m_axis_tlast  = out_tlast_reg;
  assign m_axis_tuser  = out_tuser_reg;

  // Ready is only granted for next cycle if a beat arriving then has somewhere to land.
  assign tready_early = m_axis_tready || (!temp_tvalid_reg && (!out_tvalid_reg || !s_axis_tvalid));

  always_comb begin
    out_tvalid_next   = out_tvalid_reg;
    temp_tvalid_next  = temp_tvalid_reg;
    store_in_to_out   = 1'b0;
    store_in_to_temp  = 1'b0;
    store_temp_to_out = 1'b0;
    if (tready_reg) begin
      if (m_axis_tready || !out_tvalid_reg) begin
        out_tvalid_next = s_axis_tvalid;
        store_in_to_out = 1'b1;
      end else begin
        temp_tvalid_next = s_axis_tvalid;
        store_in_to_temp = 1'b1;
      end
    end else if (m_axis_tready) begin
      out_tvalid_next   = temp_tvalid_reg;
      temp_tvalid_next  = 1'b0;
      store_temp_to_out = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_tvalid_reg  <= 1'b0;
      temp_tvalid_reg <= 1'b0;
      tready_reg      <= 1'b0;
      out_tdata_reg   <= '0;
      out_tlast_reg   <= 1'b0;
      out_tuser_reg   <= 1'b0;
      temp_tdata_reg  <= '0;
      temp_tlast_reg  <= 1'b0;
      temp_tuser_reg  <= 1'b0;
    end else begin
      out_tvalid_reg  <= out_tvalid_next;
      temp_tvalid_reg <= temp_tvalid_next;
      tready_reg      <= tready_early;
      if (store_in_to_out) begin
        out_tdata_reg <= s_axis_tdata;
        out_tlast_reg <= s_axis_tlast;
        out_tuser_reg <= s_axis_tuser;
      end else if (store_temp_to_out) begin
        out_tdata_reg <= temp_tdata_reg;
        out_tlast_reg <= temp_tlast_reg;
        out_tuser_reg <= temp_tuser_reg;
      end
      if (store_in_to_temp) begin
        temp_tdata_reg <= s_axis_tdata;
        temp_tlast_reg <= s_axis_tlast;
        temp_tuser_reg <= s_axis_tuser;
      end
    end
  end

endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet header inserter: prepends dest MAC, src MAC and EtherType to a payload
// stream and emits a single 8-bit AXI4-Stream frame toward the GMII transmitter.
module eth_frame_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy
);

  import eth_pkg::*;

  localparam int         HDR_W    = 8 * ETH_HDR_LEN;
  localparam logic [3:0] HDR_LAST = 4'(ETH_HDR_LEN - 1);

  eth_tx_state_t         state_reg, state_next;
  logic [3:0]            hdr_cnt_reg, hdr_cnt_next;
  logic [HDR_W-1:0]      hdr_shift_reg, hdr_shift_next;
  logic                  busy_reg, busy_next;
  logic                  hdr_ready_reg, hdr_ready_next;

  logic [DATA_WIDTH-1:0] int_tdata;
  logic                  int_tvalid, int_tlast, int_tuser;
  logic                  m_axis_tready_int;
  logic                  payload_tready;

  assign payload_tready            = (state_reg == PAYLOAD) && m_axis_tready_int;
  assign s_eth_payload_axis_tready = payload_tready;
  assign s_eth_hdr_ready           = hdr_ready_reg;
  assign busy                      = busy_reg;

  always_comb begin
    state_next     = state_reg;
    hdr_cnt_next   = hdr_cnt_reg;
    hdr_shift_next = hdr_shift_reg;
    busy_next      = busy_reg;
    int_tdata      = '0;
    int_tvalid     = 1'b0;
    int_tlast      = 1'b0;
    int_tuser      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s_eth_hdr_valid && hdr_ready_reg) begin
          hdr_shift_next = pack_hdr(s_eth_dest_mac, s_eth_src_mac, s_eth_type);
          hdr_cnt_next   = 4'd0;
          busy_next      = 1'b1;
          state_next     = HEADER;
        end
      end
      HEADER: begin
        if (m_axis_tready_int) begin
          int_tvalid     = 1'b1;
          int_tdata      = hdr_shift_reg[HDR_W-1 -: 8];
          hdr_shift_next = {hdr_shift_reg[HDR_W-9:0], 8'h00};
          hdr_cnt_next   = hdr_cnt_reg + 4'd1;
          if (hdr_cnt_reg == HDR_LAST) begin
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        int_tdata  = s_eth_payload_axis_tdata;
        int_tvalid = s_eth_payload_axis_tvalid && payload_tready;
        int_tlast  = s_eth_payload_axis_tlast;
        int_tuser  = s_eth_payload_axis_tuser;
        if (int_tvalid && s_eth_payload_axis_tlast) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
    // Registered so that a new header can be taken the cycle after a frame's tlast beat.
    hdr_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      hdr_cnt_reg   <= 4'd0;
      hdr_shift_reg <= '0;
      busy_reg      <= 1'b0;
      hdr_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hdr_cnt_reg   <= hdr_cnt_next;
      hdr_shift_reg <= hdr_shift_next;
      busy_reg      <= busy_next;
      hdr_ready_reg <= hdr_ready_next;
    end
  end

  axis_skid_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (int_tdata),
    .s_axis_tvalid (int_tvalid),
    .s_axis_tready (m_axis_tready_int),
    .s_axis_tlast  (int_tlast),
    .s_axis_tuser  (int_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

endmodule

// File: tb/tb_eth_frame_tx.sv
// Self-checking bench for eth_frame_tx: expected beats are queued as the bench's
// header and payload are accepted, and popped as the DUT emits frame beats.
module tb_eth_frame_tx;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_eth_hdr_valid = 1'b0;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac = '0;
  logic [47:0] s_eth_src_mac = '0;
  logic [15:0] s_eth_type = '0;
  logic [7:0]  s_eth_payload_axis_tdata = '0;
  logic        s_eth_payload_axis_tvalid = 1'b0;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast = 1'b0;
  logic        s_eth_payload_axis_tuser = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy;

  beat_t      exp_q[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         out_beats = 0;
  int         hdr_acc_cyc = 0;
  int         last_acc_cyc = 0;
  logic [7:0] last_beat_data = '0;
  logic       last_beat_user = 1'b0;
  logic       prev_stall = 1'b0;
  beat_t      prev_beat = '0;

  eth_frame_tx #(.DATA_WIDTH(8)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_eth_hdr_valid           (s_eth_hdr_valid),
    .s_eth_hdr_ready           (s_eth_hdr_ready),
    .s_eth_dest_mac            (s_eth_dest_mac),
    .s_eth_src_mac             (s_eth_src_mac),
    .s_eth_type                (s_eth_type),
    .s_eth_payload_axis_tdata  (s_eth_payload_axis_tdata),
    .s_eth_payload_axis_tvalid (s_eth_payload_axis_tvalid),
    .s_eth_payload_axis_tready (s_eth_payload_axis_tready),
    .s_eth_payload_axis_tlast  (s_eth_payload_axis_tlast),
    .s_eth_payload_axis_tuser  (s_eth_payload_axis_tuser),
    .m_axis_tdata              (m_axis_tdata),
    .m_axis_tvalid             (m_axis_tvalid),
    .m_axis_tready             (m_axis_tready),
    .m_axis_tlast              (m_axis_tlast),
    .m_axis_tuser              (m_axis_tuser),
    .busy                      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Output monitor: inputs change just after posedge, so the negedge view is what the next edge transfers.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_axis_tvalid || {m_axis_tdata, m_axis_tlast, m_axis_tuser} !== prev_beat)
          $display("[TB] FAIL stall_stable: got valid=%b beat=%h, required valid=1 beat=%h",
                   m_axis_tvalid, {m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev_beat);
        else passes++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL out_beat: got unexpected data=%h last=%b, required no beat",
                   m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== e)
            $display("[TB] FAIL out_beat: got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                     m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
          else passes++;
        end
        out_beats++;
        last_beat_data = m_axis_tdata;
        last_beat_user = m_axis_tuser;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end
  end

  task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    int tmo;
    bit done;
    tmo = 0;
    done = 0;
    s_eth_dest_mac  = d;
    s_eth_src_mac   = s;
    s_eth_type      = t;
    s_eth_hdr_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (!rst && s_eth_hdr_ready) begin
        hdr_acc_cyc = cyc;
        for (int i = 0; i < 6; i++) exp_q.push_back({d[47-8*i -: 8], 2'b00});
        for (int i = 0; i < 6; i++) exp_q.push_back({s[47-8*i -: 8], 2'b00});
        exp_q.push_back({t[15:8], 2'b00});
        exp_q.push_back({t[7:0], 2'b00});
        done = 1;
      end else if (++tmo > 2000) begin
        checks++;
        $display("[TB] FAIL hdr_accept_timeout: got ready=%b, required 1", s_eth_hdr_ready);
        done = 1;
      end
    end
    @(posedge clk); #1;
    s_eth_hdr_valid = 1'b0;
    s_eth_dest_mac  = 48'hFFEE_DDCC_BBAA;
    s_eth_src_mac   = 48'h1122_3344_5566;
    s_eth_type      = 16'hDEAD;
  endtask

  task automatic send_payload(input int len, input logic [7:0] base, input logic user, input bit gaps);
    bit acc;
    bit aborted;
    int tmo;
    aborted = 0;
    for (int i = 0; i < len && !aborted; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_eth_payload_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_eth_payload_axis_tdata  = base + 8'(i);
      s_eth_payload_axis_tlast  = (i == len - 1);
      s_eth_payload_axis_tuser  = (i == len - 1) ? user : 1'b0;
      s_eth_payload_axis_tvalid = 1'b1;
      acc = 0;
      tmo = 0;
      while (!acc && !aborted) begin
        @(negedge clk);
        if (rst) begin
          aborted = 1;
        end else if (s_eth_payload_axis_tready) begin
          acc = 1;
          exp_q.push_back({s_eth_payload_axis_tdata, s_eth_payload_axis_tlast, s_eth_payload_axis_tuser});
          if (s_eth_payload_axis_tlast) last_acc_cyc = cyc;
        end else if (++tmo > 2000) begin
          checks++;
          $display("[TB] FAIL payload_timeout: got tready=%b, required 1", s_eth_payload_axis_tready);
          aborted = 1;
        end
      end
      if (!aborted) begin
        @(posedge clk); #1;
      end
    end
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast  = 1'b0;
    s_eth_payload_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain();
    int tmo;
    tmo = 0;
    while (exp_q.size() != 0 && tmo < 3000) begin
      @(negedge clk);
      tmo++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (s_eth_hdr_ready !== 1'b0) $display("[TB] FAIL rst_hdr_ready: got %b, required 0", s_eth_hdr_ready); else passes++;
    checks++; if (s_eth_payload_axis_tready !== 1'b0) $display("[TB] FAIL rst_pl_tready: got %b, required 0", s_eth_payload_axis_tready); else passes++;
    checks++; if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL rst_tvalid: got %b, required 0", m_axis_tvalid); else passes++;
    checks++; if (m_axis_tdata !== 8'h00) $display("[TB] FAIL rst_tdata: got %h, required 00", m_axis_tdata); else passes++;
    checks++; if (m_axis_tlast !== 1'b0) $display("[TB] FAIL rst_tlast: got %b, required 0", m_axis_tlast); else passes++;
    checks++; if (m_axis_tuser !== 1'b0) $display("[TB] FAIL rst_tuser: got %b, required 0", m_axis_tuser); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b, required 0", busy); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (s_eth_hdr_ready !== 1'b1) $display("[TB] FAIL post_rst_hdr_ready: got %b, required 1", s_eth_hdr_ready); else passes++;
  endtask

  task automatic test_single_frame();
    int b0, first, n, bubbles;
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    b0 = out_beats;
    first = -1; n = 0; bubbles = 0;
    send_hdr(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h0800);
    fork
      send_payload(46, 8'h00, 1'b0, 1'b0);
      begin : watch
        int tmo;
        bit seen_last;
        tmo = 0; seen_last = 0;
        while (!seen_last && tmo < 300) begin
          @(negedge clk);
          tmo++;
          if (m_axis_tvalid) begin
            if (first < 0) first = cyc;
            n++;
            if (m_axis_tlast) seen_last = 1;
          end else if (first >= 0) begin
            bubbles++;
          end
        end
      end
    join
    checks++; if (first != hdr_acc_cyc + 2) $display("[TB] FAIL single_latency: got cycle %0d, required %0d", first, hdr_acc_cyc + 2); else passes++;
    checks++; if (n != 60) $display("[TB] FAIL single_length: got %0d beats, required 60", n); else passes++;
    checks++; if (bubbles != 0) $display("[TB] FAIL single_bubbles: got %0d, required 0", bubbles); else passes++;
    wait_drain();
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL single_drain: got %0d pending, required 0", exp_q.size()); else passes++;
    checks++; if (out_beats - b0 != 60) $display("[TB] FAIL single_count: got %0d, required 60", out_beats - b0); else passes++;
  endtask

  task automatic test_one_byte_tuser();
    int b0;
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    b0 = out_beats;
    send_hdr(48'hAA_BB_CC_DD_EE_FF, 48'h01_23_45_67_89_AB, 16'h86DD);
    send_payload(1, 8'hA5, 1'b1, 1'b0);
    wait_drain();
    checks++; if (out_beats - b0 != 15) $display("[TB] FAIL one_byte_count: got %0d, required 15", out_beats - b0); else passes++;
    checks++; if (last_beat_data !== 8'hA5) $display("[TB] FAIL one_byte_data: got %h, required a5", last_beat_data); else passes++;
    checks++; if (last_beat_user !== 1'b1) $display("[TB] FAIL one_byte_tuser: got %b, required 1", last_beat_user); else passes++;
  endtask

  task automatic test_back_to_back();
    int b0, a_last, hdr_b_cyc, t_last, t_next, busy_low;
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    b0 = out_beats;
    a_last = -100; hdr_b_cyc = -1; t_last = -1; t_next = -1; busy_low = 0;
    send_hdr(48'h10_10_10_10_10_10, 48'h20_20_20_20_20_20, 16'h0806);
    fork
      begin
        send_payload(8, 8'h10, 1'b0, 1'b0);
        a_last = last_acc_cyc;
      end
      begin
        send_hdr(48'h30_30_30_30_30_30, 48'h40_40_40_40_40_40, 16'h88F7);
        hdr_b_cyc = hdr_acc_cyc;
        send_payload(5, 8'h80, 1'b1, 1'b0);
      end
      begin : gap_watch
        int tmo;
        tmo = 0;
        while (t_next < 0 && tmo < 400) begin
          @(negedge clk);
          tmo++;
          if (!busy) busy_low++;
          if (m_axis_tvalid && t_last >= 0) t_next = cyc;
          else if (m_axis_tvalid && m_axis_tlast) t_last = cyc;
        end
      end
    join
    checks++; if (hdr_b_cyc != a_last + 1) $display("[TB] FAIL b2b_hdr_accept: got cycle %0d, required %0d", hdr_b_cyc, a_last + 1); else passes++;
    checks++; if (t_last < 0 || t_next - t_last - 1 > 2) $display("[TB] FAIL b2b_gap: got %0d cycles, required <= 2", t_next - t_last - 1); else passes++;
    checks++; if (busy_low > 1) $display("[TB] FAIL b2b_busy_low: got %0d cycles, required <= 1", busy_low); else passes++;
    wait_drain();
    checks++; if (out_beats - b0 != 41) $display("[TB] FAIL b2b_count: got %0d, required 41", out_beats - b0); else passes++;
  endtask

  task automatic test_reset_mid_header();
    int b0, tmo;
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    b0 = out_beats;
    tmo = 0;
    send_hdr(48'h55_55_55_55_55_55, 48'h66_66_66_66_66_66, 16'h0800);
    while (out_beats - b0 < 5 && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL rst_hdr_tvalid: got %b, required 0", m_axis_tvalid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_hdr_busy: got %b, required 0", busy); else passes++;
    checks++; if (m_axis_tlast !== 1'b0) $display("[TB] FAIL rst_hdr_tlast: got %b, required 0", m_axis_tlast); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (s_eth_hdr_ready !== 1'b1) $display("[TB] FAIL rst_hdr_ready_after: got %b, required 1", s_eth_hdr_ready); else passes++;
    @(posedge clk); #1;
    b0 = out_beats;
    send_hdr(48'h77_00_00_00_00_77, 48'h88_00_00_00_00_88, 16'h0800);
    send_payload(12, 8'h40, 1'b0, 1'b0);
    wait_drain();
    checks++; if (out_beats - b0 != 26) $display("[TB] FAIL rst_hdr_next_frame: got %0d beats, required 26", out_beats - b0); else passes++;
  endtask

  task automatic test_reset_mid_payload();
    int b0;
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    b0 = out_beats;
    send_hdr(48'h99_99_99_99_99_99, 48'hAB_AB_AB_AB_AB_AB, 16'h0800);
    fork
      send_payload(40, 8'h60, 1'b0, 1'b0);
      begin : rst_watch
        int tmo;
        tmo = 0;
        while (out_beats - b0 < 24 && tmo < 200) begin
          @(negedge clk);
          tmo++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL rst_pl_tvalid: got %b, required 0", m_axis_tvalid); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_pl_busy: got %b, required 0", busy); else passes++;
        checks++; if (s_eth_payload_axis_tready !== 1'b0) $display("[TB] FAIL rst_pl_ready: got %b, required 0", s_eth_payload_axis_tready); else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (s_eth_hdr_ready !== 1'b1) $display("[TB] FAIL rst_pl_hdr_ready_after: got %b, required 1", s_eth_hdr_ready); else passes++;
      end
    join
    @(posedge clk); #1;
    b0 = out_beats;
    send_hdr(48'hC0_C0_C0_C0_C0_C0, 48'hD0_D0_D0_D0_D0_D0, 16'h0800);
    send_payload(7, 8'hF0, 1'b1, 1'b0);
    wait_drain();
    checks++; if (out_beats - b0 != 21) $display("[TB] FAIL rst_pl_next_frame: got %0d beats, required 21", out_beats - b0); else passes++;
  endtask

  task automatic test_random();
    int b0, total;
    bit done;
    @(posedge clk); #1;
    b0 = out_beats;
    total = 0;
    done = 0;
    fork
      begin
        for (int f = 0; f < 200; f++) begin
          logic [63:0] rd, rs;
          int len;
          rd  = {$urandom(), $urandom()};
          rs  = {$urandom(), $urandom()};
          len = int'($urandom_range(1, 16));
          send_hdr(rd[47:0], rs[47:0], rd[63:48]);
          send_payload(len, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
          total += 14 + len;
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
        m_axis_tready = 1'b1;
      end
    join
    wait_drain();
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL random_drain: got %0d pending, required 0", exp_q.size()); else passes++;
    checks++; if (out_beats - b0 != total) $display("[TB] FAIL random_count: got %0d beats, required %0d", out_beats - b0, total); else passes++;
  endtask

  initial begin
    $display("[TB] eth_frame_tx bench start");
    test_reset();
    test_single_frame();
    test_one_byte_tuser();
    test_back_to_back();
    test_reset_mid_header();
    test_reset_mid_payload();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/eth_frame_tx.md
# eth_frame_tx

Ethernet frame header inserter for the transmit path, one stage upstream of the GMII transmitter. It accepts a header (destination MAC, source MAC, EtherType) on a valid/ready side channel and a payload byte stream on AXI4-Stream. It emits one 8-bit AXI4-Stream frame: the 14 header bytes followed by the payload. Preamble, SFD, padding and FCS are added by the downstream GMII transmitter, not here.

## Interface
- DATA_WIDTH, 8, stream width in bits; only 8 is supported.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_eth_hdr_valid  in  1  header fields valid.
- s_eth_hdr_ready  out  1  header accepted when high together with valid.
- s_eth_dest_mac  in  48  destination MAC address, transmitted MSB first.
- s_eth_src_mac  in  48  source MAC address, transmitted MSB first.
- s_eth_type  in  16  EtherType, transmitted MSB first.
- s_eth_payload_axis_tdata  in  8  payload byte.
- s_eth_payload_axis_tvalid  in  1  payload byte valid.
- s_eth_payload_axis_tready  out  1  payload byte accepted.
- s_eth_payload_axis_tlast  in  1  last payload byte.
- s_eth_payload_axis_tuser  in  1  frame-bad flag, sampled on the last byte.
- m_axis_tdata  out  8  frame byte.
- m_axis_tvalid  out  1  frame byte valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last frame byte.
- m_axis_tuser  out  1  frame-bad flag, meaningful only with tlast.
- busy  out  1  high from header accept until the last payload byte is accepted.

## Operation
- **States:**
  - IDLE: s_eth_hdr_ready=1. On valid&&ready, latch all header fields into a 112-bit shift register, set busy and move to HEADER. Input fields may change after the accept.
  - HEADER: emit one byte per cycle whenever the internal output-ready (m_axis_tready_int) is high. Byte order is dest[47:40]..dest[7:0], src[47:40]..src[7:0], type[15:8], type[7:0]. A 4-bit counter runs 0..13, with tlast=0 and tuser=0. After byte 13 is emitted, move to PAYLOAD.
  - PAYLOAD: s_eth_payload_axis_tready follows m_axis_tready_int. Each accepted beat is forwarded with tdata, tlast and tuser unchanged.
- **End of frame:** acceptance of the beat with tlast=1 clears busy and returns to IDLE.
- **Header byte vs. payload:** payload bytes presented during HEADER are never accepted; ready stays low until byte 13 has been issued.
- **One-byte payload:** tlast on the first payload beat is legal; the frame is 15 bytes.
- **Zero-byte payload:** not supported; the frame always waits for a payload beat with tlast.
- **Mid-frame idle:** if the payload has a gap (tvalid low), m_axis_tvalid drops for those cycles. No error is raised; underflow detection belongs to the GMII transmitter.
- **tuser:** propagated only on the tlast beat. Non-last payload beats are forwarded as received, and downstream ignores them.
- **Output side:** a 2-entry skid register (output reg + temp reg) makes m_axis_* and m_axis_tready_int fully registered. m_axis_tready_int_next = m_axis_tready || (!temp_valid && (!m_axis_tvalid || !int_valid)).

## Timing
- **Reset values:** s_eth_hdr_ready=0, s_eth_payload_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, busy=0, state IDLE.
- **After reset:** s_eth_hdr_ready=1 on the first cycle after rst deasserts.
- **Latency:** header accepted in cycle N → dest[47:40] valid on m_axis in cycle N+2. With m_axis_tready held high, the 14 header bytes appear in cycles N+2..N+15.
- **Header-to-payload:** if payload is valid, the first payload byte appears in N+16 with no bubble.
- **Back-to-back frames:** s_eth_hdr_ready reasserts the cycle after the tlast beat is accepted, so a new header can be accepted then. The next frame's first byte follows the previous tlast byte after at most a 2-cycle gap.
- **Backpressure:** m_axis_tready low freezes the output, and at most one extra byte is captured in the temp reg. No byte is lost or duplicated, and m_axis_tdata is stable while tvalid && !tready.
- **Reset mid-frame:** returns to IDLE and clears all valids, tlast and busy in the next cycle. Partial frame output is abandoned, and the discarded header is not replayed.

## Structure
- **Shared package eth_pkg:**
  - ETH_HDR_LEN=14 and the state encoding IDLE=0, HEADER=1, PAYLOAD=2 (2 bits).
  - Byte-offset constants DEST_OFS=0, SRC_OFS=6, TYPE_OFS=12.
- **Sub-module:** axis_skid_reg, the 2-entry registered output buffer (data, last, user, valid/ready), reused by other header inserters.

## Test plan
- **Single frame:** hdr dest=02:00:00:00:00:01, src=02:00:00:00:00:02, type=0x0800, payload 0x00..0x2D (46 bytes), m_axis_tready=1 → 60 bytes starting 02 00 00 00 00 01 02 00 00 00 00 02 08 00 00 01..2D. tlast only on byte 0x2D; first byte in N+2; no bubbles.
- **One-byte payload with tuser=1:** payload 0xA5 with tlast=1, tuser=1 → 15 bytes; byte 14=0xA5 with tlast=1, tuser=1; all header beats tuser=0.
- **Random m_axis_tready (50%) and random payload tvalid gaps over 200 frames:** output equals the expected byte sequence exactly; data is stable while stalled.
- **Back-to-back frames with a header already pending:** second hdr accepted the cycle after the first tlast beat; gap between frames ≤2 cycles; busy low for ≤1 cycle.
- **Reset asserted at header byte 5 and at payload byte 10:** m_axis_tvalid=0 and busy=0 the next cycle; hdr_ready=1 one cycle after rst release; the following frame is emitted correctly.
